// File: rtl/sub_32bit_serial.sv
// Bit-serial unsigned subtractor: diff = a - b, one SLICE-bit slice per cycle, LSB slice first.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module sub_32bit_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % SLICE) != 0 || SLICE == 0) begin : g_bad_slice
      $error("sub_32bit_serial: WIDTH must be an integer multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] diff_d;
  logic             in_ready_d, out_valid_d, borrow_out_d;
  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   sub;
`ifdef SUB_OVF_EN
  logic             overflow_d;
`endif

  // Single narrow subtract cell shared by all slices; MSB of the result is the slice borrow.
  assign a_sl = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign b_sl = b_q[int'(cnt_q)*SLICE +: SLICE];
  assign sub  = {1'b0, a_sl} - {1'b0, b_sl} - (SLICE+1)'(brw_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      brw_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_OVF_EN
      overflow   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      brw_q      <= brw_d;
      a_q        <= a_d;
      b_q        <= b_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      diff       <= diff_d;
      borrow_out <= borrow_out_d;
`ifdef SUB_OVF_EN
      overflow   <= overflow_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    a_d          = a_q;
    b_d          = b_q;
    in_ready_d   = in_ready;
    out_valid_d  = out_valid;
    diff_d       = diff;
    borrow_out_d = borrow_out;
`ifdef SUB_OVF_EN
    overflow_d   = overflow;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          diff_d     = '0;
          brw_d      = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        diff_d[int'(cnt_q)*SLICE +: SLICE] = sub[SLICE-1:0];
        brw_d = sub[SLICE];
        cnt_d = CW'(cnt_q + CW'(1));
        if (cnt_q == CW'(N - 1)) begin
          cnt_d        = '0;
          borrow_out_d = sub[SLICE];
          out_valid_d  = 1'b1;
`ifdef SUB_OVF_EN
          // Top slice holds the sign bits of both operands and of the result.
          overflow_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sub[SLICE-1] != a_q[WIDTH-1]);
`endif
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule
